regfile_dirty_flush: RTL and testbench
======================================

// Module: regfile_dirty_flush
// PURPOSE
//  4-entry register file written by one-hot register select (from the 2:4 write
//  decoder). Tracks a dirty bit per entry. On request, walks the dirty entries
//  lowest-index first, encodes each one-hot slot back to a 2-bit reg number, and
//  streams (reg_no, data) out on a valid/ready port. This is the read-out/encode
//  side of the decoder-driven write path. One random-access read port is kept
//  for normal operand reads.
// PARAMETERS
//  WIDTH   32   data width of each register and of all data ports
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  wr_en        in   1      write strobe
//  wr_onehot    in   4      one-hot register select (bit i = reg i)
//  wr_data      in   WIDTH  write data
//  wr_err       out  1      1-cycle pulse: wr_en with wr_onehot not exactly one-hot
//  rd_reg_no    in   2      random-access read select
//  rd_data      out  WIDTH  combinational: reg[rd_reg_no]
//  flush_req    in   1      start a flush (sampled in IDLE only)
//  busy         out  1      1 whenever state != IDLE
//  flush_done   out  1      1-cycle pulse: flush finished, no dirty entries left
//  out_valid    out  1      stream valid
//  out_ready    in   1      stream ready
//  out_reg_no   out  2      encoded register number of current beat
//  out_data     out  WIDTH  register snapshot of current beat
//  dirty        out  4      current dirty bits
// BEHAVIOUR
//  Reset (async, rst_n=0): regs=0, dirty=0, state=IDLE, wr_err=0, flush_done=0,
//   out_valid=0, out_reg_no=0, out_data=0. A reset in any state, including mid-beat,
//   aborts the flush immediately; no flush_done is produced.
//  Write: wr_en=1 with exactly one wr_onehot bit set -> reg[i]<=wr_data and
//   dirty[i]<=1 at the clock edge. Zero or multiple bits set -> no write, and
//   wr_err=1 in the next cycle. Writes are accepted in every state.
//  rd_data: combinational read with no bypass. A write becomes visible the
//   cycle after its edge.
//  FSM: IDLE -> SCAN -> {SEND | DONE}; SEND -> SCAN; DONE -> IDLE.
//   IDLE: out_valid=0. flush_req=1 -> SCAN.
//   SCAN: if dirty==0 -> DONE. Otherwise idx=lowest set dirty bit; latch
//    out_reg_no=idx and out_data=reg[idx] (the pre-edge value); go to SEND.
//   SEND: out_valid=1. out_reg_no and out_data stay stable until out_valid &&
//    out_ready. On that handshake, clear dirty[idx] and go to SCAN. If the same
//    edge also writes idx, dirty[idx] stays 1 and the new value is re-sent later.
//   DONE: flush_done=1 for exactly this cycle, then IDLE.
//  flush_req is ignored while busy.
//  Latency: flush_req at edge N -> SCAN in N+1 -> out_valid in N+2.
//   Handshake at edge M -> next out_valid in M+2. Beats are never back-to-back.
//  A write landing in SEND for a different, not-yet-scanned entry is included in
//   the same flush. The flush ends only when a SCAN sees dirty==0.
//  out_reg_no is always the binary encoding of a single one-hot slot (0..3).
// TESTING
//  1. Write r1=0xDEADBEEF, r3=0x12345678, then flush with out_ready=1 -> beats
//     (1,DEADBEEF) then (3,12345678); flush_done 1 cycle; dirty=0; busy drops.
//  2. Flush during the r1 beat with out_ready=0 for 5 cycles -> out_valid,
//     out_reg_no and out_data are stable all 5 cycles; beat completes on ready.
//  3. While r1 is in SEND, write r1=0xCAFEF00D -> first beat carries DEADBEEF,
//     a later beat carries (1,CAFEF00D), then flush_done.
//  4. wr_en with wr_onehot=4'b0101, and again with 4'b0000 -> no register or dirty
//     change; wr_err pulses once per attempt.
//  5. Flush with dirty=0 at edge N -> flush_done in cycle N+2; out_valid never 1.
//  6. Assert rst_n=0 mid-SEND -> all outputs 0 at once, dirty=0, no flush_done;
//     a new flush after release streams nothing and pulses flush_done.

Source files
------------

// File: rtl/regfile_dirty_flush.sv
// regfile_dirty_flush: 4-entry register file with one-hot write select, per-entry
// dirty tracking, and a flush engine. The flush engine streams each dirty entry,
// lowest index first, as (reg_no, data) on a valid/ready port.
module regfile_dirty_flush #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [3:0]       i_wr_onehot,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_wr_err,
  input  logic [1:0]       i_rd_reg_no,
  output logic [WIDTH-1:0] o_rd_data,
  input  logic             i_flush_req,
  output logic             o_busy,
  output logic             o_flush_done,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [1:0]       o_out_reg_no,
  output logic [WIDTH-1:0] o_out_data,
  output logic [3:0]       o_dirty
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // True when exactly one bit of the select is set.
  function automatic logic f_is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

  // Binary index of the lowest set bit; the caller guarantees v is non-zero.
  function automatic logic [1:0] f_lowest_idx(input logic [3:0] v);
    logic [1:0] idx;
    if (v[0]) begin
      idx = 2'd0;
    end else if (v[1]) begin
      idx = 2'd1;
    end else if (v[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_regs [4];
  logic [3:0]       r_dirty;
  logic [1:0]       r_idx;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_flush_done;
  logic             r_wr_err;

  logic             w_wr_ok;
  logic             w_handshake;
  logic             w_load_beat;
  logic             w_finish;
  logic [1:0]       w_scan_idx;
  logic [3:0]       w_set_mask;
  logic [3:0]       w_clr_mask;
  logic [3:0]       w_dirty_next;

  assign w_wr_ok     = i_wr_en && f_is_onehot(i_wr_onehot);
  // out_valid is only ever high in SEND, so it qualifies the handshake alone.
  assign w_handshake = r_out_valid && i_out_ready;
  assign w_scan_idx  = f_lowest_idx(r_dirty);
  assign w_set_mask  = w_wr_ok ? i_wr_onehot : 4'b0000;
  assign w_clr_mask  = w_handshake ? (4'b0001 << r_idx) : 4'b0000;
  // A write on the handshake edge wins over the clear, so new data is re-sent.
  assign w_dirty_next = (r_dirty & ~w_clr_mask) | w_set_mask;

  assign o_rd_data    = r_regs[i_rd_reg_no];
  assign o_busy       = (r_state != ST_IDLE);
  assign o_flush_done = r_flush_done;
  assign o_out_valid  = r_out_valid;
  assign o_out_reg_no = r_idx;
  assign o_out_data   = r_out_data;
  assign o_dirty      = r_dirty;
  assign o_wr_err     = r_wr_err;

  // Flush FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Flush FSM next-state and beat-load / finish strobes.
  always_comb begin
    w_next_state = r_state;
    w_load_beat  = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_flush_req) begin
          w_next_state = ST_SCAN;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (r_dirty == 4'b0000) begin
          w_next_state = ST_DONE;
          w_finish     = 1'b1;
        end else begin
          w_next_state = ST_SEND;
          w_load_beat  = 1'b1;
        end
      end
      ST_SEND: begin
        if (w_handshake) begin
          w_next_state = ST_SCAN;
        end else begin
          w_next_state = ST_SEND;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Register array, dirty bits and write-error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_regs[i] <= '0;
      end
      r_dirty  <= 4'b0000;
      r_wr_err <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_wr_ok && i_wr_onehot[i]) begin
          r_regs[i] <= i_wr_data;
        end
      end
      r_dirty  <= w_dirty_next;
      r_wr_err <= i_wr_en && !f_is_onehot(i_wr_onehot);
    end
  end

  // Output beat registers: snapshot in SCAN, hold through SEND until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= 2'd0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= w_finish;
      if (w_load_beat) begin
        r_idx       <= w_scan_idx;
        r_out_data  <= r_regs[w_scan_idx];
        r_out_valid <= 1'b1;
      end else if (w_handshake) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_dirty_flush.sv
// Testbench for regfile_dirty_flush: a cycle table for the basic flush and
// write-error cases, then hand-written sequences for stall, rewrite-during-send,
// empty flush and mid-beat reset.
module tb_regfile_dirty_flush;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_onehot;
  logic [31:0] wr_data;
  logic        wr_err;
  logic [1:0]  rd_reg_no;
  logic [31:0] rd_data;
  logic        flush_req;
  logic        busy;
  logic        flush_done;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_reg_no;
  logic [31:0] out_data;
  logic [3:0]  dirty;

  int total = 0;
  int bad   = 0;

  regfile_dirty_flush #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_wr_en(wr_en), .i_wr_onehot(wr_onehot), .i_wr_data(wr_data), .o_wr_err(wr_err),
    .i_rd_reg_no(rd_reg_no), .o_rd_data(rd_data),
    .i_flush_req(flush_req), .o_busy(busy), .o_flush_done(flush_done),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_reg_no(out_reg_no), .o_out_data(out_data), .o_dirty(dirty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        wr_en;
    logic [3:0]  oh;
    logic [31:0] wd;
    logic        flush;
    logic        ready;
    logic [1:0]  rd;
    logic        e_err;
    logic        e_busy;
    logic        e_fd;
    logic        e_ov;
    logic [1:0]  e_no;
    logic [31:0] e_data;
    logic [3:0]  e_dirty;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [3:0] oh, input logic [31:0] wd,
                       input logic fr, input logic rdy);
    wr_en     = we;
    wr_onehot = oh;
    wr_data   = wd;
    flush_req = fr;
    out_ready = rdy;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, ".ov"},    32'(out_valid),  32'h0);
    check({tag, ".no"},    32'(out_reg_no), 32'h0);
    check({tag, ".data"},  out_data,        32'h0);
    check({tag, ".dirty"}, 32'(dirty),      32'h0);
    check({tag, ".busy"},  32'(busy),       32'h0);
    check({tag, ".fd"},    32'(flush_done), 32'h0);
    check({tag, ".err"},   32'(wr_err),     32'h0);
  endtask

  initial begin
    // fields: we, oh, wd, flush, ready, rd | err, busy, fd, ov, no, data, dirty, rd_data
    vecs[0]  = '{1'b1, 4'b0010, 32'hDEADBEEF, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        4'b0010, 32'h0};
    vecs[1]  = '{1'b1, 4'b1000, 32'h12345678, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        4'b1010, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 4'b0000, 32'h0,        1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0,        4'b1010, 32'h12345678};
    vecs[3]  = '{1'b0, 4'b0000, 32'h0,        1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 32'hDEADBEEF, 4'b1010, 32'h12345678};
    vecs[4]  = '{1'b0, 4'b0000, 32'h0,        1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0,        4'b1000, 32'h12345678};
    vecs[5]  = '{1'b0, 4'b0000, 32'h0,        1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 32'h12345678, 4'b1000, 32'h12345678};
    vecs[6]  = '{1'b0, 4'b0000, 32'h0,        1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0,        4'b0000, 32'h12345678};
    vecs[7]  = '{1'b0, 4'b0000, 32'h0,        1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0,        4'b0000, 32'h12345678};
    vecs[8]  = '{1'b0, 4'b0000, 32'h0,        1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        4'b0000, 32'h12345678};
    vecs[9]  = '{1'b1, 4'b0101, 32'hFFFFFFFF, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        4'b0000, 32'h0};
    vecs[10] = '{1'b0, 4'b0000, 32'h0,        1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        4'b0000, 32'h0};
    vecs[11] = '{1'b1, 4'b0000, 32'h11111111, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        4'b0000, 32'hDEADBEEF};
    vecs[12] = '{1'b0, 4'b0000, 32'h0,        1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        4'b0000, 32'h12345678};

    // Reset state
    rst_n = 1'b0;
    rd_reg_no = 2'd0;
    drive(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0);
    #1;
    check_idle_zero("reset");
    check("reset.rd", rd_data, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Table: write r1/r3, flush them with ready high, then malformed writes
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].wr_en, vecs[i].oh, vecs[i].wd, vecs[i].flush, vecs[i].ready);
      rd_reg_no = vecs[i].rd;
      tick();
      check($sformatf("v%0d.err", i),   32'(wr_err),     32'(vecs[i].e_err));
      check($sformatf("v%0d.busy", i),  32'(busy),       32'(vecs[i].e_busy));
      check($sformatf("v%0d.fd", i),    32'(flush_done), 32'(vecs[i].e_fd));
      check($sformatf("v%0d.ov", i),    32'(out_valid),  32'(vecs[i].e_ov));
      check($sformatf("v%0d.dirty", i), 32'(dirty),      32'(vecs[i].e_dirty));
      check($sformatf("v%0d.rd", i),    rd_data,         vecs[i].e_rd);
      if (vecs[i].e_ov) begin
        check($sformatf("v%0d.no", i),   32'(out_reg_no), 32'(vecs[i].e_no));
        check($sformatf("v%0d.data", i), out_data,        vecs[i].e_data);
      end
    end

    // Stall: r1 beat held for 5 cycles with ready low
    drive(1'b1, 4'b0010, 32'hDEADBEEF, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'b0000, 32'h0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d.ov", k),   32'(out_valid),  32'h1);
      check($sformatf("stall%0d.no", k),   32'(out_reg_no), 32'h1);
      check($sformatf("stall%0d.data", k), out_data,        32'hDEADBEEF);
      tick();
    end
    check("stall.still_valid", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    tick();
    check("stall.hs_ov", 32'(out_valid), 32'h0);
    check("stall.hs_dirty", 32'(dirty), 32'h0);
    tick();
    check("stall.fd", 32'(flush_done), 32'h1);
    tick();
    check("stall.fd_pulse", 32'(flush_done), 32'h0);
    check("stall.busy", 32'(busy), 32'h0);

    // Rewrite r1 on the same edge as its handshake: old beat, then new beat
    drive(1'b1, 4'b0010, 32'hDEADBEEF, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'b0000, 32'h0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0);
    tick();
    check("rw.first_ov", 32'(out_valid), 32'h1);
    check("rw.first_data", out_data, 32'hDEADBEEF);
    drive(1'b1, 4'b0010, 32'hCAFEF00D, 1'b0, 1'b1);
    tick();
    check("rw.hs_ov", 32'(out_valid), 32'h0);
    check("rw.dirty_kept", 32'(dirty), 32'h2);
    drive(1'b0, 4'b0000, 32'h0, 1'b0, 1'b1);
    tick();
    check("rw.second_ov", 32'(out_valid), 32'h1);
    check("rw.second_no", 32'(out_reg_no), 32'h1);
    check("rw.second_data", out_data, 32'hCAFEF00D);
    tick();
    check("rw.dirty_clr", 32'(dirty), 32'h0);
    check("rw.fd_early", 32'(flush_done), 32'h0);
    tick();
    check("rw.fd", 32'(flush_done), 32'h1);
    tick();
    check("rw.idle", 32'(busy), 32'h0);

    // Empty flush: flush_done two cycles after the request edge, no beats
    drive(1'b0, 4'b0000, 32'h0, 1'b1, 1'b1);
    tick();
    check("empty.busy", 32'(busy), 32'h1);
    check("empty.fd_n1", 32'(flush_done), 32'h0);
    check("empty.ov_n1", 32'(out_valid), 32'h0);
    flush_req = 1'b0;
    tick();
    check("empty.fd_n2", 32'(flush_done), 32'h1);
    check("empty.ov_n2", 32'(out_valid), 32'h0);
    tick();
    check("empty.fd_off", 32'(flush_done), 32'h0);
    check("empty.idle", 32'(busy), 32'h0);

    // Reset mid-beat aborts the flush with no flush_done
    drive(1'b1, 4'b0100, 32'h0BADF00D, 1'b0, 1'b0);
    rd_reg_no = 2'd2;
    tick();
    drive(1'b0, 4'b0000, 32'h0, 1'b1, 1'b0);
    tick();
    flush_req = 1'b0;
    tick();
    check("rst.pre_ov", 32'(out_valid), 32'h1);
    check("rst.pre_no", 32'(out_reg_no), 32'h2);
    check("rst.pre_data", out_data, 32'h0BADF00D);
    rst_n = 1'b0;
    #1;
    check_idle_zero("rst.now");
    check("rst.rd", rd_data, 32'h0);
    tick();
    check("rst.hold_fd", 32'(flush_done), 32'h0);
    rst_n = 1'b1;
    flush_req = 1'b1;
    tick();
    check("rst.new_busy", 32'(busy), 32'h1);
    check("rst.new_ov1", 32'(out_valid), 32'h0);
    flush_req = 1'b0;
    tick();
    check("rst.new_fd", 32'(flush_done), 32'h1);
    check("rst.new_ov2", 32'(out_valid), 32'h0);
    tick();
    check("rst.new_idle", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
